// File: rtl/ahb_ram_slave.sv
// AHB-lite style single-port 64-bit RAM responder with a sticky error flag for bad accesses.
// Define AHB_RAM_WAIT_EN to build the programmable wait-state logic (WAIT_STATES cycles per transfer).
module ahb_ram_slave #(
  parameter int unsigned DEPTH       = 512,
  parameter logic [63:0] BASE_ADDR   = 64'h0,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [63:0] HADDR,
  input  logic        HWRITE,
  input  logic        HTRANS,
  input  logic [63:0] HWDATA,
  output logic [63:0] HRDATA,
  output logic        HREADY,
  output logic        ERR
);

  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam logic [63:0] MEM_BYTES = 64'(DEPTH) << 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              dp_valid;
  logic              dp_write;
  logic              dp_bad;
  logic [IDX_W-1:0]  dp_idx;
  logic [63:0]       mem [DEPTH];
  logic [63:0]       offset;
  logic              addr_bad;
  logic              accept;
  logic              dp_done;
  logic              mem_we;

  // Addresses below BASE_ADDR wrap to huge offsets, so one unsigned compare catches both ends.
  assign offset   = HADDR - BASE_ADDR;
  assign addr_bad = (HADDR[2:0] != 3'b000) || (offset >= MEM_BYTES);
  assign accept   = HTRANS && HREADY;
  assign dp_done  = (state == S_DATA) && dp_valid;
  assign mem_we   = dp_done && dp_write && !dp_bad;

`ifdef AHB_RAM_WAIT_EN
  localparam logic [3:0] WAIT_LOAD    = 4'(WAIT_STATES);
  localparam state_t     ACCEPT_STATE = (WAIT_STATES == 0) ? S_DATA : S_WAIT;

  logic [3:0] wait_cnt;
  logic [3:0] wait_cnt_nxt;
`else
  localparam state_t ACCEPT_STATE = S_DATA;

  logic [3:0] unused_wait_states;
  assign unused_wait_states = 4'(WAIT_STATES);
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
`ifdef AHB_RAM_WAIT_EN
      wait_cnt <= 4'd0;
`endif
    end else begin
      state    <= state_nxt;
`ifdef AHB_RAM_WAIT_EN
      wait_cnt <= wait_cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
`ifdef AHB_RAM_WAIT_EN
    wait_cnt_nxt = wait_cnt;
`endif
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = ACCEPT_STATE;
`ifdef AHB_RAM_WAIT_EN
          wait_cnt_nxt = WAIT_LOAD;
`endif
        end
      end
`ifdef AHB_RAM_WAIT_EN
      S_WAIT: begin
        wait_cnt_nxt = wait_cnt - 4'd1;
        if (wait_cnt <= 4'd1) begin
          state_nxt = S_DATA;
        end
      end
`endif
      S_DATA: begin
        if (accept) begin
          state_nxt = ACCEPT_STATE;
`ifdef AHB_RAM_WAIT_EN
          wait_cnt_nxt = WAIT_LOAD;
`endif
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    HREADY = 1'b1;
    HRDATA = '0;
`ifdef AHB_RAM_WAIT_EN
    if (state == S_WAIT) begin
      HREADY = 1'b0;
    end
`endif
    if (dp_done && !dp_write && !dp_bad) begin
      HRDATA = mem[dp_idx];
    end
  end

  // Data-phase registers capture the address phase; a back-to-back accept simply overwrites them.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_bad   <= 1'b0;
      dp_idx   <= '0;
    end else if (accept) begin
      dp_valid <= 1'b1;
      dp_write <= HWRITE;
      dp_bad   <= addr_bad;
      dp_idx   <= offset[IDX_W+2:3];
    end else if (dp_done) begin
      dp_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[dp_idx] <= HWDATA;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ERR <= 1'b0;
    end else if (dp_done && dp_bad) begin
      ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Directed plus randomized bench for ahb_ram_slave, checked against an array model of the RAM.
// Builds with or without AHB_RAM_WAIT_EN; the expected stall count follows the macro.
module tb_ahb_ram_slave;

  localparam int          DEPTH = 16;
  localparam logic [63:0] BASE  = 64'h0000_0000_0000_1000;
`ifdef AHB_RAM_WAIT_EN
  localparam int W = 3;
`else
  localparam int W = 0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic [63:0] HADDR;
  logic        HWRITE;
  logic        HTRANS;
  logic [63:0] HWDATA;
  logic [63:0] HRDATA;
  logic        HREADY;
  logic        ERR;

  logic [63:0] model_mem [DEPTH];
  logic        model_err;
  int          checks   = 0;
  int          failures = 0;

  ahb_ram_slave #(
    .DEPTH(DEPTH),
    .BASE_ADDR(BASE),
    .WAIT_STATES(3)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .HADDR(HADDR),
    .HWRITE(HWRITE),
    .HTRANS(HTRANS),
    .HWDATA(HWDATA),
    .HRDATA(HRDATA),
    .HREADY(HREADY),
    .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit isGood(input logic [63:0] a);
    logic [63:0] off;
    off = a - BASE;
    return (a[2:0] == 3'd0) && (off < 64'(DEPTH) * 64'd8);
  endfunction

  function automatic int wordOf(input logic [63:0] a);
    logic [63:0] off;
    off = a - BASE;
    return int'(off >> 3);
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] goodAddr();
    return BASE + 64'($urandom_range(0, DEPTH - 1)) * 64'd8;
  endfunction

  function automatic logic [63:0] badAddr();
    case ($urandom_range(0, 2))
      0:       return BASE + 64'(DEPTH) * 64'd8 + 64'($urandom_range(0, 7)) * 64'd8;
      1:       return BASE - 64'($urandom_range(1, 8)) * 64'd8;
      default: return goodAddr() + 64'($urandom_range(1, 7));
    endcase
  endfunction

  // Runs one data phase after its acceptance edge; the caller may already have the next address phase on the bus.
  task automatic finishPhase(input string tag, input bit wr, input logic [63:0] a, input logic [63:0] d);
    logic [63:0] exp_rd;
    for (int i = 0; i < W; i++) begin
      checkOutput({tag, " stall"}, 64'(HREADY), 64'd0);
      checkOutput({tag, " stall-rdata"}, HRDATA, 64'd0);
      @(posedge CLK); #1;
    end
    checkOutput({tag, " ready"}, 64'(HREADY), 64'd1);
    if (!wr) begin
      exp_rd = isGood(a) ? model_mem[wordOf(a)] : 64'd0;
      checkOutput({tag, " rdata"}, HRDATA, exp_rd);
    end
    @(posedge CLK); #1;
    if (wr && isGood(a)) model_mem[wordOf(a)] = d;
    if (!isGood(a)) model_err = 1'b1;
    checkOutput({tag, " err"}, 64'(ERR), 64'(model_err));
  endtask

  task automatic applyStimulus(input string tag, input bit wr, input logic [63:0] a, input logic [63:0] d);
    HADDR  = a;
    HWRITE = wr;
    HTRANS = 1'b1;
    HWDATA = rnd64();
    checkOutput({tag, " idle-ready"}, 64'(HREADY), 64'd1);
    @(posedge CLK); #1;
    HTRANS = 1'b0;
    HADDR  = rnd64();
    HWRITE = 1'($urandom_range(0, 1));
    HWDATA = d;
    finishPhase(tag, wr, a, d);
  endtask

  // Second address phase is held on the bus through the first one's wait states.
  task automatic applyPair(input string tag, input bit wr_a, input logic [63:0] a_a, input logic [63:0] d_a,
                           input bit wr_b, input logic [63:0] a_b, input logic [63:0] d_b);
    HADDR  = a_a;
    HWRITE = wr_a;
    HTRANS = 1'b1;
    @(posedge CLK); #1;
    HADDR  = a_b;
    HWRITE = wr_b;
    HWDATA = d_a;
    finishPhase({tag, " A"}, wr_a, a_a, d_a);
    HTRANS = 1'b0;
    HADDR  = rnd64();
    HWDATA = d_b;
    finishPhase({tag, " B"}, wr_b, a_b, d_b);
  endtask

  initial begin
    model_err = 1'b0;
    RST    = 1'b1;
    HTRANS = 1'b0;
    HWRITE = 1'b0;
    HADDR  = '0;
    HWDATA = '0;
    #12;
    checkOutput("reset hready", 64'(HREADY), 64'd1);
    checkOutput("reset hrdata", HRDATA, 64'd0);
    checkOutput("reset err", 64'(ERR), 64'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus("init", 1'b1, BASE + 64'(i) * 64'd8, 64'd0);
    end

    applyStimulus("deadbeef wr", 1'b1, BASE + 64'h10, 64'hDEAD_BEEF_0123_4567);
    applyStimulus("deadbeef rd", 1'b0, BASE + 64'h10, 64'd0);
    checkOutput("deadbeef err", 64'(ERR), 64'd0);

    applyPair("b2b wr-rd", 1'b1, BASE + 64'h8, 64'h1, 1'b0, BASE + 64'h8, 64'd0);

    for (int i = 0; i < 60; i++) begin
      applyPair("rand good", 1'($urandom_range(0, 1)), goodAddr(), rnd64(),
                1'($urandom_range(0, 1)), goodAddr(), rnd64());
    end
    for (int i = 0; i < 20; i++) begin
      applyStimulus("rand single", 1'($urandom_range(0, 1)), goodAddr(), rnd64());
    end
    checkOutput("good-only err", 64'(ERR), 64'd0);

    applyStimulus("word0 set", 1'b1, BASE, 64'h0123_4567_89AB_CDEF);
    applyStimulus("oob read", 1'b0, BASE + 64'(DEPTH) * 64'd8, 64'd0);
    checkOutput("oob err", 64'(ERR), 64'd1);
    applyStimulus("misaligned wr", 1'b1, BASE + 64'h3, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus("word0 intact", 1'b0, BASE, 64'd0);
    applyStimulus("below base rd", 1'b0, BASE - 64'h8, 64'd0);

    for (int i = 0; i < 40; i++) begin
      applyPair("rand mixed", 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? badAddr() : goodAddr(), rnd64(),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? badAddr() : goodAddr(), rnd64());
    end

    for (int i = 0; i < 10; i++) begin
      HTRANS = 1'b0;
      HADDR  = rnd64();
      HWRITE = 1'($urandom_range(0, 1));
      HWDATA = rnd64();
      @(posedge CLK); #1;
      checkOutput("idle hready", 64'(HREADY), 64'd1);
      checkOutput("idle hrdata", HRDATA, 64'd0);
      checkOutput("idle err sticky", 64'(ERR), 64'd1);
    end
    applyStimulus("idle mem intact", 1'b0, BASE + 64'h10, 64'd0);

    applyStimulus("rst-mid clear", 1'b1, BASE + 64'h20, 64'd0);
    HADDR  = BASE + 64'h20;
    HWRITE = 1'b1;
    HTRANS = 1'b1;
    @(posedge CLK); #1;
    HTRANS = 1'b0;
    HWDATA = 64'hFF;
    checkOutput("rst-mid pending", 64'(HREADY), (W == 0) ? 64'd1 : 64'd0);
    #2 RST = 1'b1;
    #1;
    checkOutput("rst-mid hready", 64'(HREADY), 64'd1);
    checkOutput("rst-mid err", 64'(ERR), 64'd0);
    model_err = 1'b0;
    #2 RST = 1'b0;
    @(posedge CLK); #1;
    checkOutput("rst-mid next hready", 64'(HREADY), 64'd1);
    checkOutput("rst-mid next hrdata", HRDATA, 64'd0);
    applyStimulus("rst-mid readback", 1'b0, BASE + 64'h20, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
